// File: rtl/gg_deblock_pkg.sv
// Shared types for the deblock sequencer: 4x4 block and quad layouts,
// edge-strength type, FSM states and quad slot indices.
package gg_deblock_pkg;

   typedef logic [0:15][7:0] blk4x4_t;
   typedef blk4x4_t [0:3]    quad_t;
   typedef logic [2:0]       bs_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_FILT,
      S_WB,
      S_EMIT,
      S_FLUSH,
      S_DRAIN
   } dbk_state_t;

   localparam int QUAD_ALE = 0;
   localparam int QUAD_ABV = 1;
   localparam int QUAD_LEF = 2;
   localparam int QUAD_CUR = 3;

   // line-buffer word: 128 pixel bits followed by a 6-bit qp
   localparam int LB_W = 134;

endpackage

// File: rtl/gg_deblock_linebuf.sv
// Above line buffer: one partially filtered block (pixels + qp) per column.
// One synchronous read port and one synchronous write port; the sequencer
// never reads and writes the same address in the same cycle.
module gg_deblock_linebuf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 134
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem [DEPTH];

   // registered read, plain write; contents need no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/gg_deblock_seq.sv
// Deblock sequencer around the combinational 2x2-quad filter.
// Optional macro GG_DEBLOCK_BYPASS_EN adds dbk_disable, which forces all
// filter edge strengths to zero for the picture latched at start.
//
// state    | meaning
// IDLE     | waiting for start
// ACCEPT   | in_ready high, take cur block, read above block from line buffer
// FILT     | quad driven to the filter
// WB       | filtered quad captured into ale/lef registers and line buffer
// EMIT     | holding one output block until out_ready
// FLUSH    | end of row: lef block to line buffer, last ale block emitted
// DRAIN    | bottom row emitted from the line buffer
module gg_deblock_seq
   import gg_deblock_pkg::*;
#(
   parameter int MAX_W_BLK = 64,
   parameter int W_BITS    = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [W_BITS-1:0] pic_w_blk,
   input  logic [W_BITS-1:0] pic_h_blk,
   input  logic              ch_flag,
   input  logic [4:0]        FilterOffsetA,
   input  logic [4:0]        FilterOffsetB,
`ifdef GG_DEBLOCK_BYPASS_EN
   input  logic              dbk_disable,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_blk,
   input  logic [5:0]        in_qp,
   input  logic [2:0]        in_bs_lef,
   input  logic [2:0]        in_bs_top,
   output logic [511:0]      flt_blki,
   output logic [8:0]        flt_bs,
   output logic [23:0]       flt_qpz,
   output logic              flt_ch_flag,
   output logic [4:0]        flt_ofsA,
   output logic [4:0]        flt_ofsB,
   input  logic [511:0]      flt_blko,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_blk,
   output logic [W_BITS-1:0] out_x,
   output logic [W_BITS-1:0] out_y,
   output logic              done
);

   dbk_state_t state, state_nxt;

   logic [W_BITS-1:0] w_reg, h_reg, x, y;
   logic              ch_reg;
   logic [4:0]        ofsa_reg, ofsb_reg;
`ifdef GG_DEBLOCK_BYPASS_EN
   logic              dis_reg;
`endif

   blk4x4_t    cur_blk, lef_blk, ale_blk, abv_blk;
   logic [5:0] cur_qp, lef_qp, ale_qp, abv_qp;
   bs_t        cur_bs_lef, cur_bs_top, lef_bs_top;
   logic       flush_emit, dr_pend;

   logic              lb_rd_en, lb_wr_en;
   logic [W_BITS-1:0] lb_wr_addr;
   logic [LB_W-1:0]   lb_rd_data, lb_wr_data;

   quad_t            blki, blko;
   logic [0:2][2:0]  bs;
   logic [0:3][5:0]  qpz;

   logic ohs, x_first, y_first, x_last, y_last;
   logic do_adv, do_row_end, ld_wb, ld_flush, ld_drain, dr_issue, dr_step, fin;

   assign ohs     = out_valid && out_ready;
   assign x_first = (x == '0);
   assign y_first = (y == '0);
   assign x_last  = (x == w_reg - 1'b1);
   assign y_last  = (y == h_reg - 1'b1);
   assign blko    = flt_blko;
   assign {abv_blk, abv_qp} = lb_rd_data;

   // partially filtered lef block goes above; at row end the unfiltered-again lef register does
   assign lb_wr_en   = (state == S_WB && !x_first) || (state == S_FLUSH);
   assign lb_wr_addr = (state == S_FLUSH) ? x : x - 1'b1;
   assign lb_wr_data = (state == S_FLUSH) ? {lef_blk, lef_qp} : {blko[QUAD_LEF], lef_qp};

   gg_deblock_linebuf #(
      .DEPTH (MAX_W_BLK),
      .AW    (W_BITS),
      .DW    (LB_W)
   ) u_linebuf (
      .clk     (clk),
      .rd_en   (lb_rd_en),
      .rd_addr (x),
      .rd_data (lb_rd_data),
      .wr_en   (lb_wr_en),
      .wr_addr (lb_wr_addr),
      .wr_data (lb_wr_data)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state and per-cycle control strobes
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      lb_rd_en   = 1'b0;
      do_adv     = 1'b0;
      do_row_end = 1'b0;
      ld_wb      = 1'b0;
      ld_flush   = 1'b0;
      ld_drain   = 1'b0;
      dr_issue   = 1'b0;
      dr_step    = 1'b0;
      fin        = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_ACCEPT;
         S_ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               lb_rd_en  = 1'b1;
               state_nxt = S_FILT;
            end
         end
         S_FILT:   state_nxt = S_WB;
         S_WB: begin
            if (!x_first && !y_first) begin
               ld_wb     = 1'b1;
               state_nxt = S_EMIT;
            end else begin
               do_adv = 1'b1;
            end
         end
         S_EMIT: begin
            if (ohs) begin
               if (flush_emit) do_row_end = 1'b1;
               else            do_adv     = 1'b1;
            end
         end
         S_FLUSH: begin
            if (!y_first) begin
               ld_flush  = 1'b1;
               state_nxt = S_EMIT;
            end else begin
               do_row_end = 1'b1;
            end
         end
         S_DRAIN: begin
            if (ohs) begin
               if (x_last) begin
                  fin       = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  dr_step = 1'b1;
               end
            end else if (dr_pend) begin
               ld_drain = 1'b1;
            end else if (!out_valid) begin
               dr_issue = 1'b1;
               lb_rd_en = 1'b1;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
      if (do_adv)     state_nxt = x_last ? S_FLUSH : S_ACCEPT;
      if (do_row_end) state_nxt = y_last ? S_DRAIN : S_ACCEPT;
   end

   // quad to the filter; slots outside the picture are zeroed
   always_comb begin
      blki = '0;
      bs   = '0;
      qpz  = '0;
      if (state == S_FILT || state == S_WB) begin
         blki[QUAD_CUR] = cur_blk;
         qpz[QUAD_CUR]  = cur_qp;
         if (!x_first) begin
            blki[QUAD_LEF] = lef_blk;
            qpz[QUAD_LEF]  = lef_qp;
            bs[0]          = cur_bs_lef;
         end
         if (!y_first) begin
            blki[QUAD_ALE] = ale_blk;
            blki[QUAD_ABV] = abv_blk;
            qpz[QUAD_ALE]  = ale_qp;
            qpz[QUAD_ABV]  = abv_qp;
            bs[2]          = cur_bs_top;
         end
         if (!x_first && !y_first) bs[1] = lef_bs_top;
`ifdef GG_DEBLOCK_BYPASS_EN
         if (dis_reg) bs = '0;
`endif
      end
   end

   assign flt_blki    = blki;
   assign flt_bs      = bs;
   assign flt_qpz     = qpz;
   assign flt_ch_flag = ch_reg;
   assign flt_ofsA    = ofsa_reg;
   assign flt_ofsB    = ofsb_reg;

   // datapath: config latch, block registers, counters and output register
   always_ff @(posedge clk) begin
      if (reset) begin
         w_reg      <= '0;
         h_reg      <= '0;
         x          <= '0;
         y          <= '0;
         ch_reg     <= 1'b0;
         ofsa_reg   <= '0;
         ofsb_reg   <= '0;
`ifdef GG_DEBLOCK_BYPASS_EN
         dis_reg    <= 1'b0;
`endif
         cur_blk    <= '0;
         cur_qp     <= '0;
         cur_bs_lef <= '0;
         cur_bs_top <= '0;
         lef_blk    <= '0;
         lef_qp     <= '0;
         lef_bs_top <= '0;
         ale_blk    <= '0;
         ale_qp     <= '0;
         flush_emit <= 1'b0;
         dr_pend    <= 1'b0;
         out_valid  <= 1'b0;
         out_blk    <= '0;
         out_x      <= '0;
         out_y      <= '0;
         done       <= 1'b0;
      end else begin
         done <= fin;
         if (state == S_IDLE && start) begin
            w_reg      <= pic_w_blk;
            h_reg      <= pic_h_blk;
            ch_reg     <= ch_flag;
            ofsa_reg   <= FilterOffsetA;
            ofsb_reg   <= FilterOffsetB;
`ifdef GG_DEBLOCK_BYPASS_EN
            dis_reg    <= dbk_disable;
`endif
            x          <= '0;
            y          <= '0;
            flush_emit <= 1'b0;
            dr_pend    <= 1'b0;
         end
         if (in_ready && in_valid) begin
            cur_blk    <= in_blk;
            cur_qp     <= in_qp;
            cur_bs_lef <= in_bs_lef;
            cur_bs_top <= in_bs_top;
         end
         if (state == S_WB) begin
            ale_blk    <= blko[QUAD_ABV];
            ale_qp     <= abv_qp;
            lef_blk    <= blko[QUAD_CUR];
            lef_qp     <= cur_qp;
            lef_bs_top <= cur_bs_top;
         end
         if (ld_wb) begin
            out_blk   <= blko[QUAD_ALE];
            out_x     <= x - 1'b1;
            out_y     <= y - 1'b1;
            out_valid <= 1'b1;
         end
         if (ld_flush) begin
            out_blk    <= ale_blk;
            out_x      <= x;
            out_y      <= y - 1'b1;
            out_valid  <= 1'b1;
            flush_emit <= 1'b1;
         end
         if (dr_issue) dr_pend <= 1'b1;
         if (ld_drain) begin
            out_blk   <= lb_rd_data[LB_W-1 -: 128];
            out_x     <= x;
            out_y     <= y;
            out_valid <= 1'b1;
            dr_pend   <= 1'b0;
         end
         if (ohs) out_valid <= 1'b0;
         if (do_adv && !x_last) x <= x + 1'b1;
         if (dr_step) x <= x + 1'b1;
         if (do_row_end) begin
            flush_emit <= 1'b0;
            x          <= '0;
            if (!y_last) y <= y + 1'b1;
         end
      end
   end

endmodule
